bcd_serial_adder: RTL

//  Multi-digit packed-BCD adder. Adds two DIGITS-wide operands serially, one

---
 rtl/bcd_serial_adder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bcd_serial_adder.sv
// Serial packed-BCD adder: one decimal digit per clock, least significant
// digit first, with a carry flop chaining the digit steps.
//
// Handshake: start is level-sampled on every rising clk edge and is accepted
// whenever the FSM is not in ADD (IDLE or DONE). Operands and cin only need to
// be valid in the accepting cycle. busy is high while digits are processed.
// done pulses for one cycle when sum/cout/invalid have been refreshed.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout,
    output logic                  invalid
);

    localparam int W     = 4 * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     res_q, res_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             err_q, err_d;
    logic             cout_q, cout_d;
    logic             inv_q, inv_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept;
    logic             last_digit;
    logic [4:0]       t;
    logic [4:0]       t_adj;
    logic             gt9;
    logic [3:0]       digit;
    logic             digit_bad;

    // A new op can be taken in IDLE, and in DONE for back-to-back operation.
    assign accept     = start && (state_q != S_ADD);
    assign last_digit = (idx_q == IDX_W'(DIGITS - 1));

    // Single-digit BCD step on the current low digit of the operand shifters.
    always_comb begin
        t         = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
        t_adj     = t + 5'd6;
        gt9       = (t > 5'd9);
        digit     = gt9 ? t_adj[3:0] : t[3:0];
        digit_bad = (a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9);
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ADD;
            S_ADD:   if (last_digit) state_d = S_DONE;
            S_DONE:  state_d = start ? S_ADD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: operand/result shifters, carry chain, error flag, result load.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        err_d   = err_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        inv_d   = inv_q;
        if (accept) begin
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            idx_d   = '0;
            err_d   = 1'b0;
        end else if (state_q == S_ADD) begin
            // Operands shift down so the active digit is always bits [3:0];
            // result digits enter at the top and end up in LSD-first order.
            a_d            = a_q >> 4;
            b_d            = b_q >> 4;
            res_d          = res_q >> 4;
            res_d[W-1 -: 4] = digit;
            carry_d        = gt9;
            idx_d          = idx_q + IDX_W'(1);
            err_d          = err_q | digit_bad;
            if (last_digit) begin
                // An op with any non-BCD input digit reports only invalid.
                sum_d  = err_d ? '0 : res_d;
                cout_d = err_d ? 1'b0 : gt9;
                inv_d  = err_d;
            end
        end
    end

    // Output decode from the next state so busy/done are registered.
    always_comb begin
        busy_d = (state_d == S_ADD);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            cout_q  <= 1'b0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            cout_q  <= cout_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign sum     = sum_q;
    assign cout    = cout_q;
    assign invalid = inv_q;

endmodule
